servo_frame_scheduler: RTL and testbench

//  Time-multiplexes one slot counter across all servo outputs, giving one hobby-servo PWM frame.
//  The frame is NUM_CH slots of SLOT_TICKS ticks. Channel k owns slot k and pulses high for PULSE_BASE+pos[k] ticks.
//  It sits behind the XMEM register decoder. Decoded servo writes arrive as wr_en/wr_ch/wr_pos.

---
 rtl/servo_frame_scheduler_pkg.sv | 22 ++
 rtl/servo_frame_scheduler_tick_gen.sv | 33 +++
 rtl/servo_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_servo_frame_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/servo_frame_scheduler_pkg.sv
// Shared constants, state encoding and width helper for the servo frame scheduler.
package servo_frame_scheduler_pkg;

    localparam int         SRV_POS_W      = 10;
    localparam logic [9:0] SRV_POS_CENTER = 10'd512;
    localparam int         SRV_CH_W       = 3;
    localparam int         SRV_WIDTH_W    = 11;

    typedef enum logic {
        SRV_RUN_HIGH = 1'b0,
        SRV_RUN_LOW  = 1'b1
    } srv_state_e;

    // Pulse width in ticks; 11 bits always hold base + 1023 for the supported bases.
    function automatic logic [SRV_WIDTH_W-1:0] srv_width(
        input logic [SRV_WIDTH_W-1:0] base,
        input logic [SRV_POS_W-1:0]   pos
    );
        return base + {1'b0, pos};
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_tick_gen.sv
// Tick prescaler for the servo frame scheduler: one tick every TICK_DIV clocks.
module srv_tick_gen #(
    parameter int TICK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick_o = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (tick_o) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Multiplexes one slot counter across NUM_CH servo outputs with frame-aligned position updates.
// Optional per-channel enable mask is built in when SRV_CH_ENABLE_EN is defined.
module servo_frame_scheduler
    import servo_frame_scheduler_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int TICK_DIV   = 8,
    parameter int SLOT_TICKS = 3333,
    parameter int PULSE_BASE = 988
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SRV_CH_W-1:0]  wr_ch,
    input  logic [SRV_POS_W-1:0] wr_pos,
`ifdef SRV_CH_ENABLE_EN
    input  logic [NUM_CH-1:0]    en_mask,
`endif
    output logic [NUM_CH-1:0]    Servo,
    output logic                 frame_start,
    output logic [SRV_CH_W-1:0]  cur_ch
);

    localparam int                     CNT_W    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SLOT_TICKS - 1);
    localparam logic [SRV_CH_W-1:0]    CH_LAST  = SRV_CH_W'(NUM_CH - 1);
    localparam logic [SRV_CH_W:0]      CH_COUNT = (SRV_CH_W + 1)'(NUM_CH);
    localparam logic [SRV_WIDTH_W-1:0] BASE_W   = SRV_WIDTH_W'(PULSE_BASE);

    logic tick;
    logic slotEnd;
    logic frameEnd;
    logic wrHit;
    logic pulseActive;
    logic [SRV_WIDTH_W-1:0] pulseWidth;

    srv_state_e            state_q, state_d;
    logic [CNT_W-1:0]      slotCnt_q, slotCnt_d;
    logic [SRV_CH_W-1:0]   curCh_q, curCh_d;
    logic [NUM_CH-1:0]     servo_q, servo_d;
    logic                  frameStart_q, frameStart_d;
    logic [SRV_POS_W-1:0]  shadowPos_q [NUM_CH];
    logic [SRV_POS_W-1:0]  shadowPos_d [NUM_CH];
    logic [SRV_POS_W-1:0]  actPos_q [NUM_CH];
    logic [SRV_POS_W-1:0]  actPos_d [NUM_CH];
`ifdef SRV_CH_ENABLE_EN
    logic [NUM_CH-1:0]     actEn_q, actEn_d;
`endif

    srv_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    assign slotEnd    = tick && (slotCnt_q == CNT_LAST);
    assign frameEnd   = slotEnd && (curCh_q == CH_LAST);
    assign wrHit      = wr_en && ({1'b0, wr_ch} < CH_COUNT);
    assign pulseWidth = srv_width(BASE_W, actPos_q[curCh_q]);

    // Slot FSM: high phase until the counter reaches the pulse width, low until the slot wraps.
    always_comb begin
        state_d   = state_q;
        slotCnt_d = slotCnt_q;
        curCh_d   = curCh_q;
        if (tick) begin
            if (slotEnd) begin
                slotCnt_d = '0;
                curCh_d   = (curCh_q == CH_LAST) ? '0 : curCh_q + 1'b1;
                state_d   = SRV_RUN_HIGH;
            end else begin
                slotCnt_d = slotCnt_q + 1'b1;
                if ((state_q == SRV_RUN_HIGH) && (32'(slotCnt_d) == 32'(pulseWidth))) begin
                    state_d = SRV_RUN_LOW;
                end
            end
        end
    end

    always_comb begin
        pulseActive = (state_q == SRV_RUN_HIGH) && (32'(slotCnt_q) < 32'(pulseWidth));
`ifdef SRV_CH_ENABLE_EN
        pulseActive = pulseActive && actEn_q[curCh_q];
`endif
        servo_d      = '0;
        if (pulseActive) begin
            servo_d = NUM_CH'(1) << curCh_q;
        end
        frameStart_d = frameEnd;
    end

    // A write landing on the boundary cycle flows through shadowPos_d straight into act.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            shadowPos_d[k] = shadowPos_q[k];
            if (wrHit && (wr_ch == SRV_CH_W'(k))) begin
                shadowPos_d[k] = wr_pos;
            end
            actPos_d[k] = frameEnd ? shadowPos_d[k] : actPos_q[k];
        end
`ifdef SRV_CH_ENABLE_EN
        actEn_d = frameEnd ? en_mask : actEn_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SRV_RUN_HIGH;
            slotCnt_q    <= '0;
            curCh_q      <= '0;
            servo_q      <= '0;
            frameStart_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadowPos_q[k] <= SRV_POS_CENTER;
                actPos_q[k]    <= SRV_POS_CENTER;
            end
`ifdef SRV_CH_ENABLE_EN
            actEn_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slotCnt_q    <= slotCnt_d;
            curCh_q      <= curCh_d;
            servo_q      <= servo_d;
            frameStart_q <= frameStart_d;
            for (int k = 0; k < NUM_CH; k++) begin
                shadowPos_q[k] <= shadowPos_d[k];
                actPos_q[k]    <= actPos_d[k];
            end
`ifdef SRV_CH_ENABLE_EN
            actEn_q      <= actEn_d;
`endif
        end
    end

    assign Servo       = servo_q;
    assign frame_start = frameStart_q;
    assign cur_ch      = curCh_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed testbench for servo_frame_scheduler with a short slot (TICK_DIV=1, 1100-tick slots).
module tb_servo_frame_scheduler;

    localparam int NUM_CH     = 6;
    localparam int TICK_DIV   = 1;
    localparam int SLOT_TICKS = 1100;
    localparam int PULSE_BASE = 4;
    localparam int WAIT_LIMIT = 8000;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        wr_en  = 1'b0;
    logic [2:0]  wr_ch  = '0;
    logic [9:0]  wr_pos = '0;
    logic [5:0]  enMask = '1;
    logic [5:0]  Servo;
    logic        frame_start;
    logic [2:0]  cur_ch;

    int cyc        = 0;
    int checkCount = 0;
    int failCount  = 0;
    int oneHotErr  = 0;
    int fsTimes[$];

    servo_frame_scheduler #(
        .NUM_CH     (NUM_CH),
        .TICK_DIV   (TICK_DIV),
        .SLOT_TICKS (SLOT_TICKS),
        .PULSE_BASE (PULSE_BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_pos      (wr_pos),
`ifdef SRV_CH_ENABLE_EN
        .en_mask     (enMask),
`endif
        .Servo       (Servo),
        .frame_start (frame_start),
        .cur_ch      (cur_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if ($countones(Servo) > 1) oneHotErr++;
        if (frame_start === 1'b1) fsTimes.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ch, input logic [9:0] pos);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_pos = pos;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic waitLevel(input int ch, input logic lvl, output int at);
        int n;
        n = 0;
        while ((Servo[ch] !== lvl) && (n < WAIT_LIMIT)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitBound", (n < WAIT_LIMIT) ? 32'd1 : 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic measureSlot(input int ch, output int rise, output int width);
        int f;
        waitLevel(ch, 1'b1, rise);
        waitLevel(ch, 1'b0, f);
        width = f - rise;
    endtask

    function automatic int fsAt(input int idx);
        return (fsTimes.size() > idx) ? fsTimes[idx] : -1;
    endfunction

    initial begin
        int rel, rel2, r, f, w, r0, r1;

        repeat (3) @(negedge clk);
        checkOutput("resetServo", Servo, 0);
        checkOutput("resetFrameStart", frame_start, 0);
        checkOutput("resetCurCh", cur_ch, 0);
        rst = 1'b0;
        rel = cyc;

        // Frame 0: centre positions everywhere.
        waitLevel(0, 1'b1, r0);
        checkOutput("f0Ch0Rise", r0 - rel, 1);
        waitLevel(0, 1'b0, f);
        checkOutput("f0Ch0Width", f - r0, 516);
        waitLevel(1, 1'b1, r1);
        checkOutput("f0Ch0Low", r1 - f, 584);
        checkOutput("f0Ch1Delta", r1 - r0, 1100);
        checkOutput("f0CurCh1", cur_ch, 1);
        applyStimulus(3'd2, 10'd0);
        applyStimulus(3'd7, 10'd0);
        waitLevel(1, 1'b0, f);
        measureSlot(2, r, w);
        checkOutput("f0Ch2Rise", r - rel, 2201);
        checkOutput("f0Ch2Width", w, 516);
        waitLevel(3, 1'b1, r);
        applyStimulus(3'd3, 10'd100);
        waitLevel(3, 1'b0, f);
        checkOutput("f0Ch3Width", f - r, 516);
        measureSlot(4, r, w);
        checkOutput("f0Ch4Width", w, 516);
        measureSlot(5, r, w);
        checkOutput("f0Ch5Width", w, 516);
        checkOutput("f0CurCh5", cur_ch, 5);

        // Frame 1: new positions for ch2 and ch3 take effect.
        measureSlot(0, r, w);
        checkOutput("f1Ch0Rise", r - rel, 6601);
        checkOutput("f1FrameStart", fsAt(0) - rel, 6600);
        checkOutput("f1Ch0Width", w, 516);
        measureSlot(1, r, w);
        checkOutput("f1Ch1Width", w, 516);
        measureSlot(2, r, w);
        checkOutput("f1Ch2Rise", r - rel, 8801);
        checkOutput("f1Ch2Width", w, 4);
        measureSlot(3, r, w);
        checkOutput("f1Ch3Width", w, 104);
        measureSlot(4, r, w);
        checkOutput("f1Ch4Width", w, 516);
        measureSlot(5, r, w);
        checkOutput("f1Ch5Width", w, 516);
        while (cyc < rel + 13199) @(negedge clk);
        applyStimulus(3'd5, 10'd1023);

        // Frame 2: boundary write to ch5 is bypassed into this frame.
        measureSlot(0, r, w);
        checkOutput("f2Ch0Rise", r - rel, 13201);
        checkOutput("f2FramePeriod", fsAt(1) - fsAt(0), 6600);
        waitLevel(5, 1'b1, r);
        checkOutput("f2Ch5Rise", r - rel, 18701);
        waitLevel(5, 1'b0, f);
        checkOutput("f2Ch5Width", f - r, 1027);

        // Frame 3: reset in the middle of the ch3 pulse.
        waitLevel(3, 1'b1, r);
        checkOutput("f3Ch3Rise", r - rel, 23101);
        checkOutput("f3FramePeriod", fsAt(2) - fsAt(1), 6600);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetServo", Servo, 0);
        checkOutput("midResetCurCh", cur_ch, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel2 = cyc;
        measureSlot(0, r, w);
        checkOutput("postRstCh0Rise", r - rel2, 1);
        checkOutput("postRstCh0Width", w, 516);
        measureSlot(2, r, w);
        checkOutput("postRstCh2Rise", r - rel2, 2201);
        checkOutput("postRstCh2Width", w, 516);

        checkOutput("oneHotViolations", oneHotErr, 0);
        checkOutput("frameStartCount", fsTimes.size(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
